// File: rtl/usb_tx_bit_engine.sv
// usb_tx_bit_engine: USB full-speed TX serializer with SYNC, bit stuffing, NRZI and EOP sequencing.
module usb_tx_bit_engine #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_encoded,
  output logic       eop,
  output logic       idle,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP, EOP_J} state_t;
  state_t state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0] cnt, cnt_d, ones, ones_d;
  logic [7:0] sh, sh_d;
  logic last, last_d, fin, fin_d, err, err_d;
  logic line_d, ready_d, done_d, error_d, tick, emit, bit_v;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    ones_d = ones;
    sh_d = sh;
    last_d = last;
    fin_d = fin;
    err_d = err;
    line_d = d_encoded;
    done_d = 1'b0;
    error_d = 1'b0;
    emit = 1'b0;
    bit_v = 1'b1;
    tick = timer == TW'(CLKS_PER_BIT - 1);
    timer_d = (state == IDLE || tick) ? '0 : timer + 1'b1;
    // cnt indexes the current bit of the byte; it is left alone across a stuff bit
    if (state == IDLE) begin
      if (tx_valid) begin
        state_d = SYNC;
        cnt_d = 3'd0;
        ones_d = 3'd0;
        fin_d = 1'b0;
        err_d = 1'b0;
        emit = 1'b1;
        bit_v = 1'b0;
      end
    end else if (tick) begin
      if (state == EOP) begin
        state_d = cnt[0] ? EOP_J : EOP;
        cnt_d = cnt + 3'd1;
      end else if (state == EOP_J) begin
        state_d = IDLE;
        done_d = !err;
      end else if (tx_ready && !tx_valid) begin
        state_d = EOP;
        cnt_d = 3'd0;
        error_d = 1'b1;
        err_d = 1'b1;
      end else begin
        if (tx_ready) begin
          sh_d = tx_data;
          last_d = tx_last;
        end
        fin_d = fin | (state == DATA && cnt == 3'd7 && last);
        if (ones == 3'd6) begin
          state_d = STUFF;
          emit = 1'b1;
          bit_v = 1'b0;
        end else if (fin_d) begin
          state_d = EOP;
          cnt_d = 3'd0;
        end else if (state == SYNC && cnt != 3'd7) begin
          cnt_d = cnt + 3'd1;
          emit = 1'b1;
          bit_v = cnt == 3'd6;
        end else begin
          state_d = DATA;
          cnt_d = cnt + 3'd1;
          emit = 1'b1;
          bit_v = sh_d[0];
          sh_d = {1'b0, sh_d[7:1]};
        end
      end
    end
    if (emit) begin
      line_d = bit_v ? d_encoded : !d_encoded;
      ones_d = bit_v ? ones + 3'd1 : 3'd0;
    end
    if (state_d inside {IDLE, EOP, EOP_J}) line_d = 1'b1;
    ready_d = timer == TW'(CLKS_PER_BIT - 2) && cnt == 3'd7 && (state == SYNC || (state == DATA && !last));
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      timer <= '0;
      cnt <= 3'd0;
      ones <= 3'd0;
      sh <= 8'd0;
      last <= 1'b0;
      fin <= 1'b0;
      err <= 1'b0;
      d_encoded <= 1'b1;
      eop <= 1'b0;
      idle <= 1'b1;
      tx_busy <= 1'b0;
      tx_ready <= 1'b0;
      tx_done <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      cnt <= cnt_d;
      ones <= ones_d;
      sh <= sh_d;
      last <= last_d;
      fin <= fin_d;
      err <= err_d;
      d_encoded <= line_d;
      eop <= state_d == EOP;
      idle <= state_d == IDLE;
      tx_busy <= state_d != IDLE;
      tx_ready <= ready_d;
      tx_done <= done_d;
      tx_error <= error_d;
    end
  end
endmodule

// File: tb/tb_usb_tx_bit_engine.sv
// tb_usb_tx_bit_engine: randomized packets checked by a scoreboard fed from a bit-level reference model.
module tb_usb_tx_bit_engine;
  localparam int CPB = 8;
  logic clk = 1'b0;
  logic n_rst, tx_valid, tx_last;
  logic [7:0] tx_data;
  logic tx_ready, d_encoded, eop, idle, tx_busy, tx_done, tx_error;
  int tests = 0, fails = 0;
  int sym_q[$], rdy_q[$], len_q[$], done_q[$], err_q[$];
  logic [7:0] pk [8];
  bit mon_en = 1'b0;
  usb_tx_bit_engine #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .n_rst(n_rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .d_encoded(d_encoded), .eop(eop), .idle(idle), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_error(tx_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Expected line symbols per bit time: 0 = K, 1 = J, 2 = SE0; ready offsets in clocks from start
  task automatic model(input int n, input int ur);
    bit st[$];
    int run = 0;
    int ng;
    bit line = 1'b1;
    bit last_stuff = 1'b0;
    logic [7:0] by;
    ng = (ur >= 0) ? ur : n;
    for (int j = 0; j <= ng; j++) begin
      by = (j == 0) ? 8'h80 : pk[j-1];
      for (int i = 0; i < 8; i++) begin
        st.push_back(by[i]);
        last_stuff = 1'b0;
        run = by[i] ? run + 1 : 0;
        if (i == 7 && !(ur < 0 && j == n)) rdy_q.push_back((st.size() - 1) * CPB + CPB - 1);
        if (run == 6) begin
          st.push_back(1'b0);
          run = 0;
          last_stuff = 1'b1;
        end
      end
    end
    if (ur >= 0 && last_stuff) void'(st.pop_back());
    foreach (st[k]) begin
      if (!st[k]) line = !line;
      sym_q.push_back(int'(line));
    end
    sym_q.push_back(2);
    sym_q.push_back(2);
    sym_q.push_back(1);
    len_q.push_back((st.size() + 3) * CPB);
    done_q.push_back(int'(ur < 0));
    err_q.push_back(int'(ur >= 0));
  endtask
  task automatic run_pkt(input int n, input int ur);
    int idx = 0;
    bit ok = 1'b0;
    model(n, ur);
    tx_data = pk[0];
    tx_last = n == 1;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk);
      if (!tx_busy) ok = 1'b1;
      else if (tx_ready) begin
        if (idx == ur) tx_valid = 1'b0;
        else begin
          @(posedge clk);
          #1;
          idx++;
          tx_valid = idx < n;
          if (idx < n) begin
            tx_data = pk[idx];
            tx_last = idx == n - 1;
          end
        end
      end
    end
    chk("packet_finished", int'(ok), 1);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask
  int ph = 0, cur = 0, errs = 0;
  bit busy_prev = 1'b0;
  always @(negedge clk) begin
    if (!n_rst || !mon_en) busy_prev = 1'b0;
    else if (tx_busy) begin
      ph = busy_prev ? ph + 1 : 0;
      if (!busy_prev) errs = 0;
      busy_prev = 1'b1;
      if (ph % CPB == 0) cur = sym_q.size() ? sym_q.pop_front() : 3;
      chk("line_eop_idle_d", {eop, idle, d_encoded}, cur == 3 ? 7 : cur == 2 ? 3'b101 : {2'b00, cur[0]});
      if (tx_ready) chk("ready_offset", ph, rdy_q.size() ? rdy_q.pop_front() : -1);
      if (tx_error) errs++;
      chk("done_in_packet", int'(tx_done), 0);
    end else if (busy_prev) begin
      busy_prev = 1'b0;
      chk("length", ph + 1, len_q.size() ? len_q.pop_front() : -1);
      chk("done", int'(tx_done), done_q.size() ? done_q.pop_front() : -1);
      chk("error_pulses", errs, err_q.size() ? err_q.pop_front() : -1);
      chk("symbols_left", sym_q.size(), 0);
      chk("ready_left", rdy_q.size(), 0);
      chk("idle_line", {idle, d_encoded, eop}, 3'b110);
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    n_rst = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    tx_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {d_encoded, eop, idle, tx_ready, tx_busy, tx_done, tx_error}, 7'b1010000);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {d_encoded, eop, idle, tx_busy}, 4'b1010);
    mon_en = 1'b1;
    pk[0] = 8'h00; run_pkt(1, -1);
    pk[0] = 8'hFF; run_pkt(1, -1);
    pk[0] = 8'hA5; pk[1] = 8'h3C; run_pkt(2, -1);
    run_pkt(2, 1);
    pk[0] = 8'h80; pk[1] = 8'hFF; pk[2] = 8'h01; run_pkt(3, -1);
    pk[0] = 8'hFC; pk[1] = 8'hFF; run_pkt(2, 1);
    run_pkt(2, 0);
    for (int r = 0; r < 25; r++) begin
      int n, ur;
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) pk[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      ur = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_pkt(n, ur);
    end
    chk("scoreboard_drained", len_q.size(), 0);
    mon_en = 1'b0;
    tx_data = 8'h00;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (80) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    chk("reset_mid_data", {idle, d_encoded, eop, tx_busy, tx_done}, 5'b11000);
    tx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_after_reset", {tx_busy, idle, d_encoded}, 3'b100);
    tx_valid = 1'b0;
    begin
      bit seen_err = 1'b0;
      bit ended = 1'b0;
      for (int c = 0; c < 500 && !ended; c++) begin
        @(negedge clk);
        if (tx_error) seen_err = 1'b1;
        if (!tx_busy) begin
          ended = 1'b1;
          chk("underrun_no_done", int'(tx_done), 0);
        end
      end
      chk("underrun_ended", int'(ended), 1);
      chk("underrun_error_seen", int'(seen_err), 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
